// File: rtl/uart_msg_sequencer_pkg.sv
// Shared types and constants for the UART message sequencer: FSM state encoding
// and the four operating modes.
package uart_msg_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_ECHO = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_PER  = 2'b01;
  localparam logic [1:0] MODE_TRIG = 2'b10;
  localparam logic [1:0] MODE_ECHO = 2'b11;

endpackage

// File: rtl/uart_msg_sequencer_timer.sv
// Load/enable down-counter timing the WAIT period; expired is high while the count is zero,
// so a freshly loaded WAIT lasts exactly PERIOD_CYC enabled cycles.
module uart_msg_sequencer_timer #(
  parameter int PERIOD_CYC = 27_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(PERIOD_CYC + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(PERIOD_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams a variable-length message to uart_tx (periodic or triggered) and echoes bytes
// from uart_rx through a 1-deep holding buffer. All outputs are registered.
module uart_msg_sequencer
  import uart_msg_sequencer_pkg::*;
#(
  parameter int DATA_NUM   = 22,
  parameter int LEN_W      = 8,
  parameter int PERIOD_CYC = 27_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [1:0]            mode,
  input  logic [DATA_NUM*8-1:0] msg_data,
  input  logic [LEN_W-1:0]      msg_len,
  input  logic                  trigger,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_valid,
  input  logic                  tx_data_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_data_valid,
  output logic [LEN_W-1:0]      tx_cnt,
  output logic                  busy,
  output logic                  msg_done,
  output logic                  echo_ovf,
  output state_t                dbg_state
);

  localparam logic [LEN_W-1:0] DATA_NUM_L = LEN_W'(DATA_NUM);

  // Handshake: a byte moves in any cycle where tx_data_valid && tx_data_ready; once
  // tx_data_valid is raised, tx_data_valid and tx_data hold until that transfer.
  state_t           state, state_n, ret_state, ret_n;
  logic [LEN_W-1:0] len_q, len_n, cnt_n, len_clamp;
  logic [7:0]       data_n, echo_byte, byte_n, echo_src;
  logic             valid_n, done_n, ovf_n, echo_full, full_n;
  logic             trig_q, trig_pend, pend_n, trig_edge;
  logic             xfer, off, echo_go, send_go, echo_take, timer_load, expired;

  function automatic logic [7:0] msg_byte(input logic [DATA_NUM*8-1:0] msg,
                                          input logic [LEN_W-1:0] idx);
    msg_byte = 8'h00;
    for (int k = 0; k < DATA_NUM; k++) begin
      if (idx == LEN_W'(k)) msg_byte = msg[(DATA_NUM-1-k)*8 +: 8];
    end
  endfunction

  assign xfer      = tx_data_valid && tx_data_ready;
  assign off       = (mode == MODE_OFF);
  assign trig_edge = trigger && !trig_q;
  assign len_clamp = (msg_len > DATA_NUM_L) ? DATA_NUM_L : msg_len;
  // A byte arriving this cycle counts as pending echo, so it can pre-empt a WAIT expiry.
  assign echo_go   = !off && (echo_full || rx_data_valid);
  assign echo_src  = echo_full ? echo_byte : rx_data;
  assign dbg_state = state;

  always_comb begin
    state_n    = state;
    ret_n      = ret_state;
    len_n      = len_q;
    cnt_n      = tx_cnt;
    data_n     = tx_data;
    valid_n    = tx_data_valid;
    done_n     = 1'b0;
    timer_load = 1'b0;
    send_go    = 1'b0;
    echo_take  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (echo_go) begin
          state_n = ST_ECHO;
          ret_n   = ST_IDLE;
          data_n  = echo_src;
          valid_n = 1'b1;
        end else if (mode == MODE_PER || (mode == MODE_TRIG && (trig_edge || trig_pend))) begin
          send_go = 1'b1;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (tx_cnt == len_q - LEN_W'(1)) begin
            done_n     = 1'b1;
            cnt_n      = '0;
            valid_n    = 1'b0;
            state_n    = off ? ST_IDLE : ST_WAIT;
            timer_load = !off;
          end else if (off) begin
            cnt_n   = '0;
            valid_n = 1'b0;
            state_n = ST_IDLE;
          end else begin
            cnt_n  = tx_cnt + LEN_W'(1);
            data_n = msg_byte(msg_data, tx_cnt + LEN_W'(1));
          end
        end
      end
      ST_WAIT: begin
        // The timer only runs in WAIT, so an echo pauses the countdown without reloading it.
        if (off) begin
          state_n = ST_IDLE;
        end else if (echo_go) begin
          state_n = ST_ECHO;
          ret_n   = ST_WAIT;
          data_n  = echo_src;
          valid_n = 1'b1;
        end else if (expired) begin
          if (mode == MODE_PER) send_go = 1'b1;
          else                  state_n = ST_IDLE;
        end
      end
      ST_ECHO: begin
        if (xfer) begin
          valid_n   = 1'b0;
          echo_take = 1'b1;
          state_n   = off ? ST_IDLE : ret_state;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (send_go) begin
      len_n = len_clamp;
      cnt_n = '0;
      if (len_clamp == '0) begin
        done_n     = 1'b1;
        valid_n    = 1'b0;
        state_n    = ST_WAIT;
        timer_load = 1'b1;
      end else begin
        state_n = ST_SEND;
        data_n  = msg_byte(msg_data, '0);
        valid_n = 1'b1;
      end
    end
  end

  // The buffer keeps its byte until that byte is accepted by uart_tx.
  always_comb begin
    full_n = echo_full && !echo_take;
    byte_n = echo_byte;
    ovf_n  = echo_ovf;
    pend_n = trig_pend | (trig_edge && (state != ST_IDLE || mode == MODE_TRIG));
    if (off) begin
      full_n = 1'b0;
      ovf_n  = 1'b0;
      pend_n = 1'b0;
    end else if (rx_data_valid) begin
      if (!full_n) begin
        full_n = 1'b1;
        byte_n = rx_data;
      end else begin
        ovf_n = 1'b1;
      end
    end
    if (send_go) pend_n = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      ret_state     <= ST_IDLE;
      len_q         <= '0;
      tx_cnt        <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      msg_done      <= 1'b0;
      busy          <= 1'b0;
      echo_ovf      <= 1'b0;
      echo_full     <= 1'b0;
      echo_byte     <= '0;
      trig_q        <= 1'b0;
      trig_pend     <= 1'b0;
    end else begin
      state         <= state_n;
      ret_state     <= ret_n;
      len_q         <= len_n;
      tx_cnt        <= cnt_n;
      tx_data       <= data_n;
      tx_data_valid <= valid_n;
      msg_done      <= done_n;
      busy          <= (state_n != ST_IDLE);
      echo_ovf      <= ovf_n;
      echo_full     <= full_n;
      echo_byte     <= byte_n;
      trig_q        <= trigger;
      trig_pend     <= pend_n;
    end
  end

  uart_msg_sequencer_timer #(.PERIOD_CYC(PERIOD_CYC)) u_timer (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .load    (timer_load),
    .en      (state == ST_WAIT),
    .expired (expired)
  );

endmodule
